// File: rtl/wired_cdb_arbiter_pkg.sv
// ============================================================================
//  Module      : wired_cdb_arbiter_pkg
//  Description : Shared types for the CDB arbiter slice: ROB id, CDB result
//                record, ROB bank count and the ROB bank helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wired_cdb_arbiter_pkg;

    // The ROB is split into two banks; CDB port k only ever writes bank k.
    localparam int _WIRED_PARAM_ROB_BANK_CNT = 2;

    localparam int ROB_RID_W  = 6;
    localparam int CDB_DATA_W = 32;

    typedef logic [ROB_RID_W-1:0] rob_rid_t;

    typedef struct packed {
        logic                  valid;
        rob_rid_t              wid;
        logic [CDB_DATA_W-1:0] wdata;
    } pipeline_cdb_t;

    // Bank a ROB entry lives in: the low bit of its id.
    function automatic logic rob_bank_of(input rob_rid_t rid);
        return rid[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/wired_cdb_bank_sel.sv
// ============================================================================
//  Module      : wired_cdb_bank_sel
//  Description : One-hot grant for a single ROB bank. Lowest-index requester
//                wins; if any requester is promoted, the lowest-index
//                promoted requester wins instead.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wired_cdb_bank_sel #(
    parameter int SRC_CNT = 4
) (
    input  logic [SRC_CNT-1:0] i_req,
    input  logic [SRC_CNT-1:0] i_promote,
    output logic [SRC_CNT-1:0] o_grant
);

    logic [SRC_CNT-1:0] w_promoted;
    logic [SRC_CNT-1:0] w_pool;

    assign w_promoted = i_req & i_promote;

    // Promoted requesters pre-empt the plain fixed-priority pool.
    assign w_pool = (|w_promoted) ? w_promoted : i_req;

    // Isolate the lowest set bit: x & -x.
    assign o_grant = w_pool & (~w_pool + SRC_CNT'(1));

endmodule

`default_nettype wire

// File: rtl/wired_cdb_arbiter.sv
// ============================================================================
//  Module      : wired_cdb_arbiter
//  Description : Merges the execution-queue result streams (ALU0, ALU1, LSU,
//                MDU) onto the two banked CDB write ports. Arbitration is per
//                ROB bank with fixed source priority; winners are registered
//                and broadcast one cycle after acceptance.
//                Optional macro WIRED_CDB_STARVE_GUARD_EN adds per-source
//                starvation counters that promote a stalled source.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wired_cdb_arbiter
    import wired_cdb_arbiter_pkg::*;
#(
    parameter int SRC_CNT      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            flush_i,
    input  pipeline_cdb_t [SRC_CNT-1:0]                     src_cdb_i,
    output logic          [SRC_CNT-1:0]                     src_ready_o,
    output pipeline_cdb_t [_WIRED_PARAM_ROB_BANK_CNT-1:0]   cdb_o
);

    localparam int BANKS = _WIRED_PARAM_ROB_BANK_CNT;

    logic [BANKS-1:0][SRC_CNT-1:0] w_req;
    logic [BANKS-1:0][SRC_CNT-1:0] w_grant;
    logic [SRC_CNT-1:0]            w_promote;
    logic [SRC_CNT-1:0]            w_granted;
    pipeline_cdb_t [BANKS-1:0]     w_sel;
    pipeline_cdb_t [BANKS-1:0]     r_cdb;

    // Split each source's request onto the bank its ROB id targets.
    always_comb begin
        w_req = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int i = 0; i < SRC_CNT; i++) begin
                w_req[b][i] = src_cdb_i[i].valid &&
                              (rob_bank_of(src_cdb_i[i].wid) == 1'(b));
            end
        end
    end

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            wired_cdb_bank_sel #(
                .SRC_CNT   (SRC_CNT)
            ) u_bank_sel (
                .i_req     (w_req[b]),
                .i_promote (w_promote),
                .o_grant   (w_grant[b])
            );
        end
    endgenerate

    // A source can win at most one bank, so the bank grants simply OR together.
    always_comb begin
        w_granted = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_granted = w_granted | w_grant[b];
        end
    end

    // Nothing is accepted during flush or while reset is held.
    assign src_ready_o = w_granted & {SRC_CNT{~flush_i & rst_n}};

    // Route each bank's winning payload; an idle bank yields an all-zero record.
    always_comb begin
        w_sel = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int i = 0; i < SRC_CNT; i++) begin
                if (w_grant[b][i]) begin
                    w_sel[b] = src_cdb_i[i];
                end
            end
        end
    end

    // Broadcast registers: the only path from sources to the CDB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cdb <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                r_cdb[b] <= flush_i ? '0 : w_sel[b];
            end
        end
    end

    assign cdb_o = r_cdb;

`ifdef WIRED_CDB_STARVE_GUARD_EN
    localparam int                     STARVE_CW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_CW-1:0]   STARVE_MAX = STARVE_CW'(STARVE_LIMIT);

    logic [SRC_CNT-1:0][STARVE_CW-1:0] r_starve;

    // Count cycles a source waits with a valid result; saturate at the limit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SRC_CNT; i++) begin
            if (!rst_n || flush_i || src_ready_o[i]) begin
                r_starve[i] <= '0;
            end else if (src_cdb_i[i].valid && (r_starve[i] != STARVE_MAX)) begin
                r_starve[i] <= r_starve[i] + STARVE_CW'(1);
            end
        end
    end

    // A source that has waited the full limit jumps the fixed priority.
    always_comb begin
        w_promote = '0;
        for (int i = 0; i < SRC_CNT; i++) begin
            w_promote[i] = (r_starve[i] == STARVE_MAX);
        end
    end
`else
    assign w_promote = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wired_cdb_arbiter.sv
// ============================================================================
//  Module      : tb_wired_cdb_arbiter
//  Description : Self-checking bench for wired_cdb_arbiter: directed scenarios
//                followed by randomized traffic, compared each cycle against a
//                behavioural model of the banked fixed-priority merge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wired_cdb_arbiter;
    import wired_cdb_arbiter_pkg::*;

    localparam int SRC_CNT      = 4;
    localparam int STARVE_LIMIT = 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       flush_i = 1'b0;
    pipeline_cdb_t [SRC_CNT-1:0] src_cdb;
    logic [SRC_CNT-1:0]         src_ready;
    pipeline_cdb_t [1:0]        cdb;

    int                         n_checks = 0;
    int                         n_pass   = 0;
    logic [SRC_CNT-1:0]         obs_rdy;
    int                         grant_at;

`ifdef WIRED_CDB_STARVE_GUARD_EN
    int                         starve [SRC_CNT];
`endif

    wired_cdb_arbiter #(
        .SRC_CNT      (SRC_CNT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .src_cdb_i    (src_cdb),
        .src_ready_o  (src_ready),
        .cdb_o        (cdb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic pipeline_cdb_t mk(input rob_rid_t wid, input logic [31:0] d);
        pipeline_cdb_t e;
        e.valid = 1'b1;
        e.wid   = wid;
        e.wdata = d;
        return e;
    endfunction

    // Reference: per bank, pick the lowest-index valid source aimed at it
    // (promoted sources first when the guard is built in).
    task automatic model(output logic [SRC_CNT-1:0] rdy, output pipeline_cdb_t [1:0] nxt);
        int win;
        rdy = '0;
        nxt = '0;
        for (int b = 0; b < 2; b++) begin
            win = -1;
`ifdef WIRED_CDB_STARVE_GUARD_EN
            for (int i = 0; i < SRC_CNT; i++)
                if (win < 0 && src_cdb[i].valid && src_cdb[i].wid[0] == 1'(b) &&
                    starve[i] == STARVE_LIMIT)
                    win = i;
`endif
            for (int i = 0; i < SRC_CNT; i++)
                if (win < 0 && src_cdb[i].valid && src_cdb[i].wid[0] == 1'(b))
                    win = i;
            if (win >= 0 && rst_n && !flush_i) begin
                rdy[win] = 1'b1;
                nxt[b]   = src_cdb[win];
            end
        end
    endtask

    // One clock: apply controls, check ready, clock, check broadcast, retire.
    task automatic step(input logic fl, input logic rn, input string tag);
        logic [SRC_CNT-1:0]  erdy;
        pipeline_cdb_t [1:0] enxt;
        flush_i = fl;
        rst_n   = rn;
        #1;
        model(erdy, enxt);
        obs_rdy = src_ready;
        chk({tag, ".ready"}, 64'(src_ready), 64'(erdy));
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("%s.cdb%0d.valid", tag, b), 64'(cdb[b].valid), 64'(enxt[b].valid));
            if (enxt[b].valid || !rn)
                chk($sformatf("%s.cdb%0d.entry", tag, b), 64'(cdb[b]), 64'(enxt[b]));
        end
`ifdef WIRED_CDB_STARVE_GUARD_EN
        for (int i = 0; i < SRC_CNT; i++) begin
            if (!rn || fl || erdy[i]) starve[i] = 0;
            else if (src_cdb[i].valid && starve[i] < STARVE_LIMIT) starve[i]++;
        end
`endif
        for (int i = 0; i < SRC_CNT; i++)
            if (!rn || fl || erdy[i]) src_cdb[i] = '0;
    endtask

    initial begin
        src_cdb = '0;
`ifdef WIRED_CDB_STARVE_GUARD_EN
        for (int i = 0; i < SRC_CNT; i++) starve[i] = 0;
`endif
        @(posedge clk);
        #1;

        // Reset state
        src_cdb[1] = mk(6'd9, 32'h1111_0000);
        step(1'b0, 1'b0, "reset0");
        step(1'b0, 1'b0, "reset1");

        // ALU0 bank0 and MDU bank1 together: both accepted
        src_cdb[0] = mk(6'd4, 32'hA0A0_0004);
        src_cdb[3] = mk(6'd7, 32'hD3D3_0007);
        step(1'b0, 1'b1, "dual");

        // ALU0 and LSU collide on bank0: LSU waits a cycle
        src_cdb[0] = mk(6'd2, 32'hA0A0_0002);
        src_cdb[2] = mk(6'd6, 32'hC2C2_0006);
        step(1'b0, 1'b1, "collide");
        step(1'b0, 1'b1, "retry");

        // Idle, then lone LSU on bank1
        step(1'b0, 1'b1, "idle");
        src_cdb[2] = mk(6'd3, 32'hC2C2_0003);
        step(1'b0, 1'b1, "single");
        step(1'b0, 1'b1, "idle2");

        // Flush with ALU1 pending
        src_cdb[1] = mk(6'd5, 32'hB1B1_0005);
        step(1'b1, 1'b1, "flush");
        step(1'b0, 1'b1, "postflush");

        // Reset asserted with outputs registered valid
        src_cdb[0] = mk(6'd10, 32'hA0A0_000A);
        src_cdb[1] = mk(6'd11, 32'hB1B1_000B);
        step(1'b0, 1'b1, "prerst");
        src_cdb[2] = mk(6'd12, 32'hC2C2_000C);
        step(1'b0, 1'b0, "rstmid");
        step(1'b0, 1'b1, "postrst");

        // ALU0 hogs bank0 while MDU waits on bank0
        step(1'b1, 1'b1, "preflush");
        src_cdb[3] = mk(6'd8, 32'hD3D3_0008);
        grant_at = 0;
        for (int k = 1; k <= 12; k++) begin
            src_cdb[0] = mk(6'(2 * k), 32'(k));
            step(1'b0, 1'b1, "starve");
            if (obs_rdy[3] && grant_at == 0) grant_at = k;
        end
`ifdef WIRED_CDB_STARVE_GUARD_EN
        chk("starve.grant_cycle", 64'(grant_at), 64'(STARVE_LIMIT + 1));
`else
        chk("starve.grant_cycle", 64'(grant_at), 64'(0));
`endif
        src_cdb = '0;
        step(1'b1, 1'b1, "clear");

        // Randomized traffic; losers hold their payload until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < SRC_CNT; i++)
                if (!src_cdb[i].valid && $urandom_range(0, 9) < 6)
                    src_cdb[i] = mk(6'($urandom), 32'($urandom));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
